// File: rtl/bram_dma_ctrl.sv
// bram_dma_ctrl: command-driven DMA between AXI-stream ports and BRAM port A.
// Optional write-side tlast checking is enabled with BRAM_DMA_CTRL_TLAST_CHECK_EN.
module bram_dma_ctrl #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [15:0]           cmd_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  output logic [15:0]           dma_write_pointer,
  output logic                  dma_rd_en,
  output logic [15:0]           dma_read_pointer,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      wr_ptr;
  logic [LEN_W-1:0]      rd_ptr;
  logic [LEN_W-1:0]      out_idx;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_wp;
  logic                  fifo_rp;
  logic [OCC_W-1:0]      fifo_cnt;
  logic [OCC_W-1:0]      occ_after_pop;
  logic                  rd_pend;
  logic                  accept;
  logic                  pop;
  logic                  wr_last;
  logic                  last_out;

  assign accept        = cmd_valid && (state == S_IDLE);
  assign wr_last       = (wr_ptr == len_q - LEN_W'(1));
  assign last_out      = (out_idx == len_q - LEN_W'(1));
  assign m_axis_tvalid = (fifo_cnt != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  // FIFO words plus the in-flight read, after this cycle's pop; a new read may issue only below 2
  assign occ_after_pop = fifo_cnt + OCC_W'(rd_pend) - OCC_W'(pop);

  assign m_axis_tdata      = m_axis_tvalid ? fifo_mem[fifo_rp] : '0;
  assign m_axis_tlast      = m_axis_tvalid && last_out;
  assign base_addr         = base_q;
  assign dma_write_pointer = wr_ptr;
  assign dma_read_pointer  = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0)  state_nxt = S_DONE;
          else if (cmd_dir)   state_nxt = S_READ;
          else                state_nxt = S_WRITE;
        end
      end
      S_WRITE: if (dma_wr_en && wr_last) state_nxt = S_DONE;
      S_READ:  if (pop && last_out)      state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    s_axis_tready = 1'b0;
    dma_wr_en     = 1'b0;
    dma_wr_data   = '0;
    dma_rd_en     = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_WRITE: begin
        busy          = 1'b1;
        s_axis_tready = 1'b1;
        dma_wr_en     = s_axis_tvalid;
        dma_wr_data   = s_axis_tdata;
      end
      S_READ: begin
        busy      = 1'b1;
        dma_rd_en = (rd_ptr != len_q) && (occ_after_pop < OCC_W'(2));
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointers, command latch and read-return FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_idx  <= '0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= '0;
      rd_pend  <= 1'b0;
    end else if (accept) begin
      base_q   <= cmd_base;
      len_q    <= cmd_len;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_idx  <= '0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      if (dma_wr_en) wr_ptr <= wr_ptr + LEN_W'(1);
      if (dma_rd_en) rd_ptr <= rd_ptr + LEN_W'(1);
      rd_pend <= dma_rd_en;
      if (rd_pend) fifo_wp <= ~fifo_wp;
      if (pop) begin
        fifo_rp <= ~fifo_rp;
        out_idx <= out_idx + LEN_W'(1);
      end
      fifo_cnt <= occ_after_pop;
    end
  end

  // BRAM returns data one cycle after dma_rd_en
  always_ff @(posedge clk) begin
    if (rd_pend) fifo_mem[fifo_wp] <= dma_rd_data;
  end

`ifdef BRAM_DMA_CTRL_TLAST_CHECK_EN
  logic err_q;

  // Sticky until the next command: tlast must mark exactly the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if (dma_wr_en && (s_axis_tlast != wr_last))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_bram_dma_ctrl.sv
// tb_bram_dma_ctrl: directed vector table plus hand-written sequences, with a behavioural BRAM.
`timescale 1ns/1ps
module tb_bram_dma_ctrl;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 15;

`ifdef BRAM_DMA_CTRL_TLAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [AW-1:0] cmd_base;
  logic [15:0]   cmd_len;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [AW-1:0] base_addr;
  logic          dma_wr_en, dma_rd_en;
  logic [DW-1:0] dma_wr_data, dma_rd_data;
  logic [15:0]   dma_write_pointer, dma_read_pointer;
  logic          busy, done, err;

  bram_dma_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .base_addr(base_addr), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .dma_write_pointer(dma_write_pointer), .dma_rd_en(dma_rd_en),
    .dma_read_pointer(dma_read_pointer), .dma_rd_data(dma_rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: address wraps at ADDR_WIDTH, one-cycle read latency
  logic [DW-1:0] mem [1<<AW];
  logic [AW-1:0] wa, ra;
  assign wa = base_addr + AW'(dma_write_pointer);
  assign ra = base_addr + AW'(dma_read_pointer);
  always @(posedge clk) begin
    if (dma_wr_en) mem[wa] <= dma_wr_data;
    if (dma_rd_en) dma_rd_data <= mem[ra];
  end

  typedef struct packed {
    logic          cr;
    logic          bsy;
    logic          dn;
    logic          str;
    logic          wen;
    logic [15:0]   wp;
    logic          ren;
    logic [15:0]   rp;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic [AW-1:0] ba;
  } obs_t;

  typedef struct {
    logic          cv;
    logic          cd;
    logic [AW-1:0] cb;
    logic [15:0]   cl;
    logic          tv;
    logic [DW-1:0] td;
    logic          tl;
    logic          mr;
    obs_t          exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  vec_t          vt [NV];
  logic [DW-1:0] got [16];
  int            got_n, tl_n, tl_idx, rd_dones, occ_viol, both_viol;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {cmd_ready, busy, done, s_axis_tready, dma_wr_en, dma_write_pointer, dma_rd_en,
         dma_read_pointer, m_axis_tvalid, m_axis_tdata, m_axis_tlast, base_addr};
    return o;
  endfunction

  // flg = {cmd_ready, busy, done, s_axis_tready, dma_wr_en}
  function automatic vec_t mkv(input logic cv, input logic cd, input logic [AW-1:0] cb,
                               input logic [15:0] cl, input logic tv, input logic [DW-1:0] td,
                               input logic tl, input logic mr, input logic [4:0] flg,
                               input logic [15:0] wp, input logic ren, input logic [15:0] rp,
                               input logic mv, input logic [DW-1:0] md, input logic ml,
                               input logic [AW-1:0] ba);
    vec_t v;
    v.cv = cv; v.cd = cd; v.cb = cb; v.cl = cl;
    v.tv = tv; v.td = td; v.tl = tl; v.mr = mr;
    v.exp = {flg, wp, ren, rp, mv, md, ml, ba};
    return v;
  endfunction

  task automatic write_xfer(input logic [AW-1:0] b, input logic [15:0] l, input logic [DW-1:0] d0,
                            input int bad, output int beats, output int dones);
    beats = 0;
    dones = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_base = b; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < int'(l) + 4; c++) begin
      s_axis_tvalid = (beats < int'(l));
      s_axis_tdata  = d0 + DW'(beats);
      s_axis_tlast  = (bad >= 0) ? (beats == bad) : (beats == int'(l) - 1);
      #1;
      if (dma_wr_en) beats++;
      if (done) dones++;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // stall=1 drives m_axis_tready with the repeating pattern 1,0,0,1; stop_at>0 leaves mid-transfer
  task automatic read_xfer(input logic [AW-1:0] b, input logic [15:0] l, input logic stall,
                           input int stop_at);
    int issued;
    int popnow;
    got_n = 0; tl_n = 0; tl_idx = -1; rd_dones = 0; occ_viol = 0; both_viol = 0; issued = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_base = b; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 4 * int'(l) + 12; c++) begin
      m_axis_tready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      popnow = (m_axis_tvalid && m_axis_tready) ? 1 : 0;
      if (dma_rd_en && dma_wr_en) both_viol++;
      if (dma_rd_en && (issued - got_n - popnow >= 2)) occ_viol++;
      if (dma_rd_en) issued++;
      if (popnow == 1) begin
        if (got_n < 16) got[got_n] = m_axis_tdata;
        if (m_axis_tlast) begin
          tl_n++;
          tl_idx = got_n;
        end
        got_n++;
      end
      if (done) rd_dones++;
      if (stop_at > 0 && got_n == stop_at) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int   beats, dones;
    obs_t rst_obs;

    rst_obs = '0;
    rst_obs.cr = 1'b1;

    // cv cd cb cl | tv td tl mr | flg wp ren rp mv md ml ba
    vt[0]  = mkv(1'b1, 1'b0, 13'h010, 16'd4, 1'b0, 32'h0,  1'b0, 1'b0, 5'b10000, 16'd0, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h000);
    vt[1]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b1, 32'hA0, 1'b0, 1'b0, 5'b01011, 16'd0, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[2]  = mkv(1'b1, 1'b1, 13'h1AA, 16'd7, 1'b1, 32'hA1, 1'b0, 1'b0, 5'b01011, 16'd1, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[3]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b1, 32'hA2, 1'b0, 1'b0, 5'b01011, 16'd2, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[4]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b1, 32'hA3, 1'b1, 1'b0, 5'b01011, 16'd3, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[5]  = mkv(1'b1, 1'b1, 13'h1AA, 16'd7, 1'b1, 32'hEE, 1'b0, 1'b0, 5'b01100, 16'd4, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[6]  = mkv(1'b1, 1'b1, 13'h010, 16'd4, 1'b1, 32'hEE, 1'b0, 1'b1, 5'b10000, 16'd4, 1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[7]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b1, 16'd0, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[8]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b1, 16'd1, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[9]  = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b1, 16'd2, 1'b1, 32'hA0, 1'b0, 13'h010);
    vt[10] = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b1, 16'd3, 1'b1, 32'hA1, 1'b0, 13'h010);
    vt[11] = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b0, 16'd4, 1'b1, 32'hA2, 1'b0, 13'h010);
    vt[12] = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01000, 16'd0, 1'b0, 16'd4, 1'b1, 32'hA3, 1'b1, 13'h010);
    vt[13] = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b01100, 16'd0, 1'b0, 16'd4, 1'b0, 32'h0,  1'b0, 13'h010);
    vt[14] = mkv(1'b0, 1'b0, 13'h000, 16'd0, 1'b0, 32'h0,  1'b0, 1'b1, 5'b10000, 16'd0, 1'b0, 16'd4, 1'b0, 32'h0,  1'b0, 13'h010);

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    #2;
    check("reset_outputs", 128'(sample()), 128'(rst_obs));
    check("reset_err", 128'(err), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Write 4 then read 4 at 0x010, with commands offered while busy
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      cmd_valid = vt[i].cv; cmd_dir = vt[i].cd; cmd_base = vt[i].cb; cmd_len = vt[i].cl;
      s_axis_tvalid = vt[i].tv; s_axis_tdata = vt[i].td; s_axis_tlast = vt[i].tl;
      m_axis_tready = vt[i].mr;
      #1;
      check($sformatf("vec%0d", i), 128'(sample()), 128'(vt[i].exp));
    end
    cmd_valid = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;

    // Read 8 under m_axis_tready stalls
    write_xfer(13'h100, 16'd8, 32'hB0, -1, beats, dones);
    check("wr8_beats", 128'(beats), 128'(8));
    check("wr8_done", 128'(dones), 128'(1));
    check("wr8_err", 128'(err), 128'(1'b0));
    read_xfer(13'h100, 16'd8, 1'b1, 0);
    check("rd8_count", 128'(got_n), 128'(8));
    for (int i = 0; i < 8; i++)
      check($sformatf("rd8_word%0d", i), 128'(got[i]), 128'(32'hB0 + 32'(i)));
    check("rd8_tlast_count", 128'(tl_n), 128'(1));
    check("rd8_tlast_idx", 128'(tl_idx), 128'(7));
    check("rd8_done", 128'(rd_dones), 128'(1));
    check("rd8_fifo_overrun", 128'(occ_viol), 128'(0));
    check("rd8_wr_rd_overlap", 128'(both_viol), 128'(0));
    m_axis_tready = 1'b0;

    // Address wrap at the BRAM end
    write_xfer(13'h1FFE, 16'd4, 32'hC0, -1, beats, dones);
    check("wrap_beats", 128'(beats), 128'(4));
    check("wrap_1ffe", 128'(mem[13'h1FFE]), 128'(32'hC0));
    check("wrap_1fff", 128'(mem[13'h1FFF]), 128'(32'hC1));
    check("wrap_0000", 128'(mem[13'h0000]), 128'(32'hC2));
    check("wrap_0001", 128'(mem[13'h0001]), 128'(32'hC3));

    // Misplaced tlast: transfer still completes
    write_xfer(13'h200, 16'd4, 32'hD0, 1, beats, dones);
    check("badlast_beats", 128'(beats), 128'(4));
    check("badlast_done", 128'(dones), 128'(1));
    check("badlast_err", 128'(err), 128'(EXP_ERR));

    // Zero-length command goes straight to DONE and clears err
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_base = 13'h055; cmd_len = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("len0_done", 128'({done, busy, cmd_ready}), 128'(3'b110));
    check("len0_err_cleared", 128'(err), 128'(1'b0));
    check("len0_base", 128'(base_addr), 128'(13'h055));
    @(negedge clk);
    #1;
    check("len0_idle", 128'({done, busy, cmd_ready}), 128'(3'b001));

    // Reset in the middle of a read, then a fresh short read
    read_xfer(13'h100, 16'd8, 1'b0, 3);
    check("rst_pre_count", 128'(got_n), 128'(3));
    check("rst_pre_word2", 128'(got[2]), 128'(32'hB2));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 128'(sample()), 128'(rst_obs));
    check("rst_mid_mvalid", 128'(m_axis_tvalid), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    read_xfer(13'h100, 16'd2, 1'b0, 0);
    check("post_rst_count", 128'(got_n), 128'(2));
    check("post_rst_word0", 128'(got[0]), 128'(32'hB0));
    check("post_rst_word1", 128'(got[1]), 128'(32'hB1));
    check("post_rst_tlast_idx", 128'(tl_idx), 128'(1));
    check("post_rst_tlast_count", 128'(tl_n), 128'(1));
    check("post_rst_done", 128'(rd_dones), 128'(1));
    m_axis_tready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
